and_gate_test_sequencer: RTL and testbench

//   Self-checking stimulus sequencer for the and_primitive datapath.
//   - On start, steps the gate inputs through every input vector, holding each for HOLD_CYCLES clocks.
//   - Samples the gate output at the end of each hold and compares it against the expected AND (&stim).
//   - Counts mismatches and reports pass/fail.
//   - Sits beside the DUT in bench and BIST wrappers, replacing hand-written #delay stimulus.

---
 rtl/and_gate_test_sequencer.sv | 118 +++++++++++
 tb/tb_and_gate_test_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/and_gate_test_sequencer.sv
// Stimulus sequencer that walks an AND gate through every input vector and scores its output.
// Define AND_SEQ_CAPTURE_EN to add the o_observed port holding the sampled dut_y per vector.
module and_gate_test_sequencer #(
    parameter int N_INPUTS    = 2,
    parameter int HOLD_CYCLES = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic                     i_dut_y,
    output logic [N_INPUTS-1:0]      o_stim,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_pass,
`ifdef AND_SEQ_CAPTURE_EN
    output logic [2**N_INPUTS-1:0]   o_observed,
`endif
    output logic [N_INPUTS:0]        o_err_count
);
    // state   | meaning
    // S_IDLE  | waiting for start; outputs hold results of the last run
    // S_DRIVE | driving o_stim, sampling dut_y on the last cycle of each hold
    // S_DONE  | one-cycle done pulse, then back to idle

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

    state_t                 r_state;
    logic [HW-1:0]          r_hold_cnt;
    logic [N_INPUTS-1:0]    r_stim;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic [N_INPUTS:0]      r_err_count;
    logic [2**N_INPUTS-1:0] r_observed;

    logic w_sample_hit;
    logic w_mismatch;
    logic w_last_vec;

    assign w_sample_hit = (r_hold_cnt == HOLD_LAST);
    assign w_mismatch   = (i_dut_y != (&r_stim));
    assign w_last_vec   = (r_stim == {N_INPUTS{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= '0;
            r_stim      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_observed  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state     <= S_DRIVE;
                        r_stim      <= '0;
                        r_busy      <= 1'b1;
                        r_err_count <= '0;
                        r_hold_cnt  <= '0;
                        r_observed  <= '0;
                    end
                end
                S_DRIVE: begin
                    // abort wins over a sample landing in the same cycle
                    if (i_abort) begin
                        r_state    <= S_IDLE;
                        r_stim     <= '0;
                        r_busy     <= 1'b0;
                        r_hold_cnt <= '0;
                    end else if (w_sample_hit) begin
                        r_hold_cnt         <= '0;
                        r_observed[r_stim] <= i_dut_y;
                        if (w_mismatch)
                            r_err_count <= r_err_count + (N_INPUTS+1)'(1);
                        if (w_last_vec) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_stim  <= '0;
                            r_pass  <= (r_err_count == '0) && !w_mismatch;
                        end else begin
                            r_stim <= r_stim + N_INPUTS'(1);
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_stim      = r_stim;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_count = r_err_count;
`ifdef AND_SEQ_CAPTURE_EN
    assign o_observed  = r_observed;
`else
    logic w_unused;
    assign w_unused = ^r_observed;
`endif

endmodule

// File: tb/tb_and_gate_test_sequencer.sv
// Randomized bench for and_gate_test_sequencer; the gate under test is a truth table lookup.
module tb_and_gate_test_sequencer;
    localparam int N  = 2;
    localparam int H  = 4;
    localparam int NV = 2**N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic          i_abort;
    logic          i_dut_y;
    logic [N-1:0]  o_stim;
    logic          o_busy;
    logic          o_done;
    logic          o_pass;
    logic [N:0]    o_err_count;
`ifdef AND_SEQ_CAPTURE_EN
    logic [NV-1:0] o_observed;
`endif

    logic [NV-1:0] tbl;
    logic          exp_pass;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    assign i_dut_y = tbl[o_stim];

    and_gate_test_sequencer #(.N_INPUTS(N), .HOLD_CYCLES(H)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_dut_y     (i_dut_y),
        .o_stim      (o_stim),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pass      (o_pass),
`ifdef AND_SEQ_CAPTURE_EN
        .o_observed  (o_observed),
`endif
        .o_err_count (o_err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // mismatches a truth table produces against AND, over the first n_vec vectors
    function automatic int ref_errs(input logic [NV-1:0] t, input int n_vec);
        int e = 0;
        for (int v = 0; v < n_vec; v++)
            if (t[v] != (v == NV-1)) e++;
        return e;
    endfunction

    // full run; called one cycle after posedge+1 while the DUT is idle
    task automatic run_check(input logic [NV-1:0] t, input bit keep_start, input bit repulse);
        int errs;
        tbl  = t;
        errs = ref_errs(t, NV);
        i_start = 1'b1;
        @(posedge clk); #1;
        if (!keep_start) i_start = 1'b0;
        check("start_busy_stim", {o_busy, o_done, 30'(o_stim)}, {1'b1, 1'b0, 30'd0});
        check("start_err_clr", 32'(o_err_count), 32'd0);
        for (int k = 1; k < NV*H; k++) begin
            @(posedge clk); #1;
            if (repulse) i_start = 1'($urandom_range(0, 1));
            check("drive_seq", {o_busy, o_done, 30'(o_stim)}, {1'b1, 1'b0, 30'(k / H)});
        end
        @(posedge clk); #1;
        i_start = keep_start;
        check("done_pulse", {o_busy, o_done, 30'(o_stim)}, {1'b0, 1'b1, 30'd0});
        check("done_err", 32'(o_err_count), 32'(errs));
        check("done_pass", 32'(o_pass), 32'(errs == 0));
`ifdef AND_SEQ_CAPTURE_EN
        check("observed", 32'(o_observed), 32'(t));
`endif
        exp_pass = (errs == 0);
        @(posedge clk); #1;
        check("idle_after_done", {o_busy, o_done}, 2'b00);
    endtask

    // abort sampled on edge e after the start edge (1 .. NV*H)
    task automatic abort_at(input logic [NV-1:0] t, input int e);
        int n_done = 0;
        int n_busy = 0;
        tbl = t;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 1; k < e; k++) begin
            @(posedge clk); #1;
        end
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        check("abort_idle", {o_busy, o_done, 30'(o_stim)}, {1'b0, 1'b0, 30'd0});
        check("abort_err_partial", 32'(o_err_count), 32'(ref_errs(t, (e-1) / H)));
        check("abort_pass_kept", 32'(o_pass), 32'(exp_pass));
        for (int k = 0; k < NV*H + 4; k++) begin
            @(posedge clk); #1;
            if (o_done) n_done++;
            if (o_busy) n_busy++;
        end
        check("abort_no_done", 32'(n_done + n_busy), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        tbl     = 4'b1000;
        exp_pass = 1'b0;
        #12;
        check("reset_outs", {o_busy, o_done, o_pass, 29'(o_err_count)}, 32'd0);
        check("reset_stim", 32'(o_stim), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_check(4'b1000, 0, 0);
        run_check(4'b1110, 0, 0);
        run_check(4'b1111, 0, 0);
        run_check(4'b0000, 0, 0);
        run_check(4'b1000, 0, 0);
        abort_at(4'b0111, 2*H + 2);
        abort_at(4'b0110, NV*H);

        // async reset mid-vector 01 after a passing run
        tbl = 4'b1011;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 1; k <= H + 1; k++) begin
            @(posedge clk); #1;
        end
        check("pre_reset_vec", {o_busy, 31'(o_stim)}, {1'b1, 31'd1});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {o_busy, o_done, o_pass, 29'(o_err_count)}, 32'd0);
        check("async_reset_stim", 32'(o_stim), 32'd0);
        exp_pass = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_check(4'b1000, 0, 0);

        run_check(4'($urandom_range(0, NV*NV-1)), 0, 1);
        run_check(4'b1000, 1, 0);
        run_check(4'($urandom_range(0, NV*NV-1)), 0, 0);
        for (int r = 0; r < 8; r++) begin
            if (r % 2 == 0)
                run_check(4'($urandom_range(0, NV*NV-1)), 0, 0);
            else
                abort_at(4'($urandom_range(0, NV*NV-1)), int'($urandom_range(1, NV*H)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
